// File: rtl/tsmem_pkg.sv
// ---------------------------------------------------------------------------
// tsmem_pkg
// Shared types and helpers for the timestamp-SRAM arbiter.
//   addr_w()   : address width needed for a w x h sensor array
//   state_t    : arbiter phase (optional clear sweep, then normal running)
//   gnt_t      : which requester was granted most recently
//   mem_cmd_t  : one SRAM command word for the default 346x260 geometry
// No ports (package).
// ---------------------------------------------------------------------------
package tsmem_pkg;

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int TS_W_ADDR    = addr_w(346, 260);
  localparam int TS_WORD_SIZE = 18;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} gnt_t;

  typedef struct packed {
    logic                    cen;
    logic                    rw;
    logic [TS_W_ADDR-1:0]    addr1;
    logic [TS_W_ADDR-1:0]    addr2;
    logic [TS_WORD_SIZE-1:0] data;
  } mem_cmd_t;

endpackage

// File: rtl/tsmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin (read client vs. write client). When both ask in
// the same cycle, the one that did not win last time is served. Ready only
// looks at the other requester's valid, never at its own.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              arbitration allowed this cycle
//   req_rd, req_wr  request valids
//   rdy_rd, rdy_wr  ready toward each requester
//   gnt_rd, gnt_wr  one-hot (or zero) grant for this cycle
// ---------------------------------------------------------------------------
module rr_arb2
  import tsmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic rdy_rd,
  output logic rdy_wr,
  output logic gnt_rd,
  output logic gnt_wr
);

  gnt_t last_grant;

  // Ready/grant: a requester is ready unless the other one is contending and
  // it is the other one's turn. The two readies are exclusive under contention.
  always_comb begin
    rdy_rd = 1'b0;
    rdy_wr = 1'b0;
    if (en) begin
      rdy_rd = !req_wr || (last_grant == GNT_WR);
      rdy_wr = !req_rd || (last_grant == GNT_RD);
    end else begin
      rdy_rd = 1'b0;
      rdy_wr = 1'b0;
    end
    gnt_rd = req_rd && rdy_rd;
    gnt_wr = req_wr && rdy_wr;
  end

  // Remember the most recent winner; reset favours read on first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_WR;
    end else if (gnt_rd) begin
      last_grant <= GNT_RD;
    end else if (gnt_wr) begin
      last_grant <= GNT_WR;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/tsmem_arbiter.sv
// ---------------------------------------------------------------------------
// tsmem_arbiter
// Shares the dual-port timestamp SRAM between the patch-read client (two words
// per access) and the event-write client. Grants are round-robin, SRAM command
// pins come straight from registers, and read data returns MEM_LAT cycles
// after the command cycle.
// Optional build macro: TSMEM_CLEAR_EN -- after reset, sweep zeros into every
// address through port 1 before accepting requests.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rd_req_vld/rdy, rd_addr1/2    read request (two addresses)
//   rd_rsp_vld, rd_rsp_data1/2    read response, no backpressure
//   wr_req_vld/rdy, wr_addr/data  write request
//   read_data1_mem/2_mem          SRAM data outputs
//   cen, rw, addr_port1/2,
//   write_data_mem                SRAM command pins (registered)
//   init_done                     high once requests are accepted
// ---------------------------------------------------------------------------
module tsmem_arbiter
  import tsmem_pkg::*;
#(
  parameter int  DVS_WIDTH  = 346,
  parameter int  DVS_HEIGHT = 260,
  parameter int  WORD_SIZE  = 18,
  parameter int  MEM_LAT    = 1,
  localparam int W_ADDR     = addr_w(DVS_WIDTH, DVS_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req_vld,
  output logic                 rd_req_rdy,
  input  logic [W_ADDR-1:0]    rd_addr1,
  input  logic [W_ADDR-1:0]    rd_addr2,
  output logic                 rd_rsp_vld,
  output logic [WORD_SIZE-1:0] rd_rsp_data1,
  output logic [WORD_SIZE-1:0] rd_rsp_data2,
  input  logic                 wr_req_vld,
  output logic                 wr_req_rdy,
  input  logic [W_ADDR-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [WORD_SIZE-1:0] read_data1_mem,
  input  logic [WORD_SIZE-1:0] read_data2_mem,
  output logic                 cen,
  output logic                 rw,
  output logic [W_ADDR-1:0]    addr_port1,
  output logic [W_ADDR-1:0]    addr_port2,
  output logic [WORD_SIZE-1:0] write_data_mem,
  output logic                 init_done
);

  state_t             state;
  logic               arb_en;
  logic               gnt_rd;
  logic               gnt_wr;
  logic               rd_issued;
  logic [MEM_LAT-1:0] vld_pipe;

`ifdef TSMEM_CLEAR_EN
  localparam int DEPTH = DVS_WIDTH * DVS_HEIGHT;

  logic [W_ADDR-1:0] clr_addr;

  // Clear sweep: one address per cycle, then hand over to normal running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_addr == W_ADDR'(DEPTH - 1)) begin
        state <= S_RUN;
      end else begin
        clr_addr <= clr_addr + W_ADDR'(1);
      end
    end else begin
      state <= state;
    end
  end
`else
  // Without the sweep the arbiter is running as soon as reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state;
    end
  end
`endif

  assign init_done = (state == S_RUN);

  // Requests issued while rst is high would be lost by the register reset,
  // so never acknowledge them.
  assign arb_en = (state == S_RUN) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req_rd (rd_req_vld),
    .req_wr (wr_req_vld),
    .rdy_rd (rd_req_rdy),
    .rdy_wr (wr_req_rdy),
    .gnt_rd (gnt_rd),
    .gnt_wr (gnt_wr)
  );

  // SRAM command registers: a grant this cycle becomes the pin command next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cen            <= 1'b1;
      rw             <= 1'b0;
      addr_port1     <= '0;
      addr_port2     <= '0;
      write_data_mem <= '0;
`ifdef TSMEM_CLEAR_EN
    end else if (state == S_CLEAR) begin
      cen            <= 1'b0;
      rw             <= 1'b1;
      addr_port1     <= clr_addr;
      write_data_mem <= '0;
`endif
    end else if (gnt_rd) begin
      cen        <= 1'b0;
      rw         <= 1'b0;
      addr_port1 <= rd_addr1;
      addr_port2 <= rd_addr2;
    end else if (gnt_wr) begin
      // Port 2 is unused by writes and keeps its last address.
      cen            <= 1'b0;
      rw             <= 1'b1;
      addr_port1     <= wr_addr;
      write_data_mem <= wr_data;
    end else begin
      cen <= 1'b1;
    end
  end

  assign rd_issued = !cen && !rw;

  // Read-valid delay line: a read on the pins in cycle c reports valid in c+MEM_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_issued;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign rd_rsp_vld   = vld_pipe[MEM_LAT-1];
  assign rd_rsp_data1 = read_data1_mem;
  assign rd_rsp_data2 = read_data2_mem;

endmodule

// File: tb/tb_tsmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tsmem_arbiter
// Two arbiter instances share the request inputs: one with MEM_LAT=1, one with
// MEM_LAT=3, each in front of its own behavioural SRAM. Directed vectors with
// hand-computed expectations. Build with +define+TSMEM_CLEAR_EN to exercise
// the clear sweep on a 4x2 array.
// ---------------------------------------------------------------------------
module tb_tsmem_arbiter;

`ifdef TSMEM_CLEAR_EN
  localparam int DW = 4;
  localparam int DH = 2;
`else
  localparam int DW = 346;
  localparam int DH = 260;
`endif
  localparam int DEPTH = DW * DH;
  localparam int AW    = $clog2(DEPTH);
  localparam int WS    = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd_req_vld;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          wr_req_vld;
  logic [AW-1:0] wr_addr;
  logic [WS-1:0] wr_data;

  logic          rd_req_rdy_1, wr_req_rdy_1, rsp_vld_1, cen_1, rw_1, init_done_1;
  logic [WS-1:0] data1_1, data2_1, mq1_1, mq2_1, wd_1;
  logic [AW-1:0] addr_port1_1, addr_port2_1;

  logic          rd_req_rdy_3, wr_req_rdy_3, rsp_vld_3, cen_3, rw_3, init_done_3;
  logic [WS-1:0] data1_3, data2_3, wd_3;
  logic [AW-1:0] addr_port1_3, addr_port2_3;
  logic [WS-1:0] mq1_3 [3];
  logic [WS-1:0] mq2_3 [3];

  int n_chk  = 0;
  int n_pass = 0;

  tsmem_arbiter #(.DVS_WIDTH(DW), .DVS_HEIGHT(DH), .WORD_SIZE(WS), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_1),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_rsp_vld(rsp_vld_1), .rd_rsp_data1(data1_1), .rd_rsp_data2(data2_1),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_1),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .read_data1_mem(mq1_1), .read_data2_mem(mq2_1),
    .cen(cen_1), .rw(rw_1), .addr_port1(addr_port1_1), .addr_port2(addr_port2_1),
    .write_data_mem(wd_1), .init_done(init_done_1)
  );

  tsmem_arbiter #(.DVS_WIDTH(DW), .DVS_HEIGHT(DH), .WORD_SIZE(WS), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_3),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_rsp_vld(rsp_vld_3), .rd_rsp_data1(data1_3), .rd_rsp_data2(data2_3),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_3),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .read_data1_mem(mq1_3[2]), .read_data2_mem(mq2_3[2]),
    .cen(cen_3), .rw(rw_3), .addr_port1(addr_port1_3), .addr_port2(addr_port2_3),
    .write_data_mem(wd_3), .init_done(init_done_3)
  );

  // Power-up contents of an unwritten SRAM word.
  function automatic logic [WS-1:0] minit(input int a);
    return WS'(a * 7 + 291);
  endfunction

  // Expected contents before any bench write (the sweep zeroes everything).
  function automatic logic [WS-1:0] exp_init(input int a);
`ifdef TSMEM_CLEAR_EN
    return WS'(a % DEPTH) & '0;
`else
    return minit(a % DEPTH);
`endif
  endfunction

  function automatic logic [AW-1:0] ma(input int a);
    return AW'(a % DEPTH);
  endfunction

  // SRAM model, latency 1.
  logic [WS-1:0] mem_1  [DEPTH];
  bit            seen_1 [DEPTH];
  always @(posedge clk) begin
    if (!cen_1 && rw_1) begin
      mem_1[addr_port1_1]  <= wd_1;
      seen_1[addr_port1_1] <= 1'b1;
    end
    if (!cen_1 && !rw_1) begin
      mq1_1 <= seen_1[addr_port1_1] ? mem_1[addr_port1_1] : minit(int'(addr_port1_1));
      mq2_1 <= seen_1[addr_port2_1] ? mem_1[addr_port2_1] : minit(int'(addr_port2_1));
    end else begin
      mq1_1 <= '0;
      mq2_1 <= '0;
    end
  end

  // SRAM model, latency 3.
  logic [WS-1:0] mem_3  [DEPTH];
  bit            seen_3 [DEPTH];
  always @(posedge clk) begin
    if (!cen_3 && rw_3) begin
      mem_3[addr_port1_3]  <= wd_3;
      seen_3[addr_port1_3] <= 1'b1;
    end
    if (!cen_3 && !rw_3) begin
      mq1_3[0] <= seen_3[addr_port1_3] ? mem_3[addr_port1_3] : minit(int'(addr_port1_3));
      mq2_3[0] <= seen_3[addr_port2_3] ? mem_3[addr_port2_3] : minit(int'(addr_port2_3));
    end else begin
      mq1_3[0] <= '0;
      mq2_3[0] <= '0;
    end
    mq1_3[1] <= mq1_3[0];
    mq1_3[2] <= mq1_3[1];
    mq2_3[1] <= mq2_3[0];
    mq2_3[2] <= mq2_3[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
    for (int i = 0; i < 200 && !init_done_1; i++) step();
    chk("init_done", 32'(init_done_1), 32'd1);
  endtask

  localparam logic [5:0] T2_RD = 6'b010101;

  initial begin
    rst = 1'b1; rd_req_vld = 1'b0; wr_req_vld = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
    step();
    step();

    // Reset values
    chk("rst_cen",   32'(cen_1),        32'd1);
    chk("rst_rw",    32'(rw_1),         32'd0);
    chk("rst_a1",    32'(addr_port1_1), 32'd0);
    chk("rst_a2",    32'(addr_port2_1), 32'd0);
    chk("rst_wd",    32'(wd_1),         32'd0);
    chk("rst_vld1",  32'(rsp_vld_1),    32'd0);
    chk("rst_vld3",  32'(rsp_vld_3),    32'd0);
`ifdef TSMEM_CLEAR_EN
    chk("rst_init",  32'(init_done_1),  32'd0);

    // Clear sweep, restarted by rst at address 3
    rst = 1'b0;
    rd_req_vld = 1'b1; wr_req_vld = 1'b1;
    settle();
    chk("clr_rdy0", 32'(rd_req_rdy_1 | wr_req_rdy_1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("clr1_a1",  32'(addr_port1_1), 32'(k));
      chk("clr1_cmd", 32'({cen_1, rw_1}), 32'd1);
      chk("clr1_rdy", 32'(rd_req_rdy_1 | wr_req_rdy_1), 32'd0);
    end
    rst = 1'b1;
    step();
    chk("clr_rst_cen",  32'(cen_1),       32'd1);
    chk("clr_rst_init", 32'(init_done_1), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      rd_req_vld = (k < 6);
      wr_req_vld = (k < 6);
      settle();
      chk("clr2_a1",   32'(addr_port1_1), 32'(k));
      chk("clr2_cmd",  32'({cen_1, rw_1}), 32'd1);
      chk("clr2_wd",   32'(wd_1),         32'd0);
      chk("clr2_init", 32'(init_done_1),  32'(k == 7));
      chk("clr2_rdy",  32'(rd_req_rdy_1 | wr_req_rdy_1), 32'(k == 7));
    end
    step();
    step();
`else
    chk("rst_init",  32'(init_done_1),  32'd1);
    rst = 1'b0;
    step();
`endif

    // T1: single read, MEM_LAT=1
    rd_req_vld = 1'b1; rd_addr1 = ma(5); rd_addr2 = ma(6);
    settle();
    chk("t1_rdy", 32'(rd_req_rdy_1), 32'd1);
    step();
    rd_req_vld = 1'b0;
    settle();
    chk("t1_cmd",  32'({cen_1, rw_1}), 32'd0);
    chk("t1_a1",   32'(addr_port1_1), 32'(ma(5)));
    chk("t1_a2",   32'(addr_port2_1), 32'(ma(6)));
    chk("t1_vld0", 32'(rsp_vld_1), 32'd0);
    step();
    chk("t1_vld",  32'(rsp_vld_1), 32'd1);
    chk("t1_d1",   32'(data1_1), 32'(exp_init(5)));
    chk("t1_d2",   32'(data2_1), 32'(exp_init(6)));
    step();
    chk("t1_vldx", 32'(rsp_vld_1), 32'd0);
    chk("t1_idle", 32'(cen_1), 32'd1);

    // T2: continuous contention alternates RD,WR,... starting with RD after reset
    do_reset();
    rd_addr1 = ma(10); rd_addr2 = ma(11); wr_addr = ma(200); wr_data = 18'h00077;
    for (int i = 0; i < 7; i++) begin
      rd_req_vld = (i < 6);
      wr_req_vld = (i < 6);
      settle();
      if (i < 6) begin
        chk("t2_rd_rdy", 32'(rd_req_rdy_1), 32'(T2_RD[i]));
        chk("t2_wr_rdy", 32'(wr_req_rdy_1), 32'(!T2_RD[i]));
        chk("t2_one",    32'(rd_req_rdy_1 & wr_req_rdy_1), 32'd0);
      end
      if (i > 0) begin
        chk("t2_rw", 32'(rw_1), 32'(!T2_RD[i-1]));
        chk("t2_a2", 32'(addr_port2_1), 32'(ma(11)));
        if (!T2_RD[i-1]) chk("t2_wa1", 32'(addr_port1_1), 32'(ma(200)));
      end
      step();
    end
    step();
    step();

    // T3: write then read same address the next cycle
    wr_req_vld = 1'b1; wr_addr = ma(100); wr_data = 18'h2ABCD;
    settle();
    chk("t3_wr_rdy", 32'(wr_req_rdy_1), 32'd1);
    step();
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b1; rd_addr1 = ma(100); rd_addr2 = ma(101);
    settle();
    chk("t3_wcmd", 32'({cen_1, rw_1}), 32'd1);
    chk("t3_wa1",  32'(addr_port1_1),  32'(ma(100)));
    chk("t3_wd",   32'(wd_1),          32'h2ABCD);
    chk("t3_rd_rdy", 32'(rd_req_rdy_1), 32'd1);
    step();
    rd_req_vld = 1'b0;
    settle();
    chk("t3_rcmd", 32'({cen_1, rw_1}), 32'd0);
    step();
    chk("t3_vld", 32'(rsp_vld_1), 32'd1);
    chk("t3_d1",  32'(data1_1), 32'h2ABCD);
    chk("t3_d2",  32'(data2_1), 32'(exp_init(101)));
    step();

    // T4: four back-to-back reads, both latencies
    do_reset();
    for (int c = 0; c < 9; c++) begin
      rd_req_vld = (c < 4);
      rd_addr1 = ma(20 + 2 * c);
      rd_addr2 = ma(21 + 2 * c);
      settle();
      if (c < 4) chk("t4_rdy", 32'(rd_req_rdy_3), 32'd1);
      chk("t4_vld3", 32'(rsp_vld_3), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) begin
        chk("t4_d1_3", 32'(data1_3), 32'(exp_init(20 + 2 * (c - 4))));
        chk("t4_d2_3", 32'(data2_3), 32'(exp_init(21 + 2 * (c - 4))));
      end
      chk("t4_vld1", 32'(rsp_vld_1), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("t4_d1_1", 32'(data1_1), 32'(exp_init(20 + 2 * (c - 2))));
      step();
    end

    // T6: rst while reads are in flight drops the pending responses
    rd_req_vld = 1'b1; rd_addr1 = ma(30); rd_addr2 = ma(31);
    settle();
    chk("t6_rd_rdy", 32'(rd_req_rdy_1), 32'd1);
    step();
    rd_req_vld = 1'b0;
    wr_req_vld = 1'b1; wr_addr = ma(300); wr_data = 18'h11111;
    settle();
    chk("t6_rcmd",   32'({cen_1, rw_1}), 32'd0);
    chk("t6_wr_rdy", 32'(wr_req_rdy_1), 32'd1);
    step();
    wr_req_vld = 1'b0;
    rst = 1'b1;
    settle();
    chk("t6_wcmd", 32'({cen_1, rw_1}), 32'd1);
    chk("t6_wa1",  32'(addr_port1_1), 32'(ma(300)));
    chk("t6_wa2",  32'(addr_port2_1), 32'(ma(31)));
    chk("t6_wd",   32'(wd_1),         32'h11111);
    chk("t6_vld1", 32'(rsp_vld_1),    32'd1);
    step();
    chk("t6_cen",  32'(cen_1),        32'd1);
    chk("t6_rw",   32'(rw_1),         32'd0);
    chk("t6_a1",   32'(addr_port1_1), 32'd0);
    chk("t6_a2",   32'(addr_port2_1), 32'd0);
    chk("t6_wd0",  32'(wd_1),         32'd0);
    chk("t6_v1x",  32'(rsp_vld_1),    32'd0);
    chk("t6_v3x",  32'(rsp_vld_3),    32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_v3_drop", 32'(rsp_vld_3), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
